alu_seq_ctrl: RTL

Sequencer and arbiter for the shared 4-bit 74181-style ALU slice, which includes the active-low carry-lookahead submodule.
- Accepts 16-bit operation requests from two requesters and grants them round-robin.
- Runs each operation as four nibble passes through the slice, LSB nibble first, rippling the active-low carry between passes in a register.
- Returns the assembled 16-bit result with carry and equality flags on a valid/ready response channel.
- Sits between the instruction-side requesters and the combinational ALU datapath.

---
 rtl/alu_seq_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: round-robin arbiter and nibble sequencer for a shared
// 4-bit 74181-style ALU slice. A W-bit operation is run as NIB passes,
// LSB nibble first, with the active-low carry rippled through a register.
module alu_seq_ctrl #(
    parameter  int W   = 16,
    localparam int NIB = W / 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    input  logic [3:0]   req_s0,
    input  logic [3:0]   req_s1,
    input  logic         req_m0,
    input  logic         req_m1,
    input  logic         req_cin_n0,
    input  logic         req_cin_n1,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [3:0]   alu_s,
    output logic         alu_m,
    output logic         alu_cn_n,
    input  logic [3:0]   alu_f,
    input  logic         alu_cn4_n,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_f,
    output logic         rsp_cout_n,
    output logic         rsp_eq
);

    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [3:0]    r_s;
    logic          r_m;
    logic          r_cin_n;
    logic          r_carry_n;
    logic [W-1:0]  r_res;
    logic          r_id;
    logic          r_cout_n;

    logic w_grant;
    logic w_gnt_id;
    logic w_last_nib;

    // Grant only in IDLE; on contention the requester not served last wins.
    // rst masks the grant so nothing is offered during a reset cycle.
    always_comb begin
        w_gnt_id   = (&req_valid) ? ~r_last : req_valid[1];
        w_grant    = (r_state == S_IDLE) && (|req_valid) && !rst;
        req_ready  = 2'b00;
        if (w_grant)
            req_ready = w_gnt_id ? 2'b10 : 2'b01;
        w_last_nib = (r_cnt == CW'(NIB - 1));
    end

    // Slice drive: current nibble of the captured operands during RUN, zero otherwise.
    always_comb begin
        alu_a    = 4'b0;
        alu_b    = 4'b0;
        alu_s    = 4'b0;
        alu_m    = 1'b0;
        alu_cn_n = 1'b0;
        if (r_state == S_RUN) begin
            alu_a    = r_a[4*r_cnt +: 4];
            alu_b    = r_b[4*r_cnt +: 4];
            alu_s    = r_s;
            alu_m    = r_m;
            alu_cn_n = (r_cnt == '0) ? r_cin_n : r_carry_n;
        end
    end

    // Sequencer state: capture on grant, one nibble per RUN cycle, hold in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_carry_n <= 1'b1;
            r_res     <= '0;
            r_id      <= 1'b0;
            r_cout_n  <= 1'b1;
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= 4'b0;
            r_m       <= 1'b0;
            r_cin_n   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_a     <= w_gnt_id ? req_a1     : req_a0;
                        r_b     <= w_gnt_id ? req_b1     : req_b0;
                        r_s     <= w_gnt_id ? req_s1     : req_s0;
                        r_m     <= w_gnt_id ? req_m1     : req_m0;
                        r_cin_n <= w_gnt_id ? req_cin_n1 : req_cin_n0;
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Carry is rippled even in logic mode; the slice ignores it there.
                    r_res[4*r_cnt +: 4] <= alu_f;
                    r_carry_n           <= alu_cn4_n;
                    if (w_last_nib) begin
                        r_cout_n <= alu_cn4_n;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Response fields come straight from registers, so they hold while stalled.
    always_comb begin
        rsp_valid  = (r_state == S_DONE);
        rsp_id     = r_id;
        rsp_f      = r_res;
        rsp_cout_n = r_cout_n;
        rsp_eq     = &r_res;
    end

endmodule
